fp32_batchnorm_mc: RTL and testbench
====================================

Name: fp32_batchnorm_mc

Overview:
Multi-channel, streaming inference batch-norm for fp32 activations: y = x*scale[c] + shift[c], with optional fused ReLU or bypass.
- Per-channel folded coefficients are precomputed by software and loaded through a config port:
  - scale = gamma/sqrt(var+eps)
  - shift = beta - mu*scale
- Sits between the conv/accumulator output stream and the activation buffer.
- Adds over the single-channel block: channel count, coefficient storage, valid/ready backpressure and mode selection.

Parameters:
NUM_CH, 16, number of channels; coefficient register depth; CH_W = max(1, clog2(NUM_CH)).
MUL_LAT, 3, pipeline stages of the fp32 multiply inside the sub-module.
ADD_LAT, 3, pipeline stages of the fp32 add inside the sub-module.
PIPE_LAT, MUL_LAT+ADD_LAT+2, total input-accept to out_valid latency (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  32  fp32 activation x
in_sof  in  1  start of frame; forces this beat to channel 0
mode  in  2  00 affine, 01 affine+ReLU, 10 bypass, 11 treated as 00; sampled per beat
rm  in  2  rounding mode, same encoding as the fp32 arithmetic cores (00 = nearest-even); sampled per beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  32  fp32 result y
out_ch  out  CH_W  channel index of out_data
cfg_we  in  1  coefficient write strobe
cfg_sel  in  1  0 = scale, 1 = shift
cfg_ch  in  CH_W  channel to write
cfg_data  in  32  fp32 coefficient

Behaviour:
- Reset (rst high at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Channel counter = 0.
  - All pipeline valid bits cleared.
  - scale[*]=0x3F800000, shift[*]=0x00000000, so a reset block is identity.
  - Reset mid-stream discards all in-flight beats; no partial outputs.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - out_data/out_ch hold stable while out_valid && !out_ready.
- Stall:
  - advance = !out_valid || out_ready.
  - in_ready = advance; it is combinational from out_ready only, never from in_valid.
  - All stages, including sub-module enables, move only when advance=1.
  - Bubbles propagate as cleared valid bits.
- Latency: exactly PIPE_LAT cycles from the accept edge to out_valid when out_ready is held high. Throughput 1 beat/cycle.
- Channel counter, per accepted beat:
  - ch = in_sof ? 0 : cnt.
  - Then cnt = (ch == NUM_CH-1) ? 0 : ch+1 (wrap).
  - ch travels with the beat and emerges as out_ch.
- Coefficient lookup:
  - Done in the accept cycle; the coefficient is registered with the beat.
  - cfg write to the same channel in the same cycle: the beat uses the OLD value; the new value applies from the next cycle.
  - cfg_ch >= NUM_CH: write ignored.
  - Config writes are accepted regardless of stall.
- Modes (mode and rm registered with the beat):
  - 00: y = round(round(x*scale)+shift) — two roundings, not fused.
  - 01: as 00, then if sign=1 and y is not NaN, y=0x00000000 (-0 also maps to +0).
  - 10: y = x bit-exact, same latency.
- Specials:
  - Any NaN operand gives canonical 0x7FC00000.
  - Inf*0 gives 0x7FC00000.
  - +Inf + -Inf gives 0x7FC00000.
  - Overflow gives ±Inf (nearest) per rm.
  - Denormal inputs are flushed to signed zero; denormal results are flushed to signed zero.

Decomposition:
- Shared package: MODE_AFFINE/MODE_RELU/MODE_BYPASS encodings, FP32_ONE, FP32_ZERO, FP32_QNAN constants, rm encodings.
- One sub-module: fp32_scale_shift.
  - Pipelined multiply then add, with enable port, latency MUL_LAT+ADD_LAT, rm input.
  - Owns all IEEE special-case handling.
- fp32_batchnorm_mc keeps coefficient registers, channel counter, valid/ch/mode side-pipeline, ReLU/bypass mux and output register.

Test Plan:
- After reset, no cfg writes; stream x=0x40A00000 (5.0) on ch0 → out_data=0x40A00000, out_ch=0, PIPE_LAT cycles after accept.
- Load ch0 scale=0x3F000000 (0.5), shift=0xBF800000 (-1.0); ch1 scale=0x40000000 (2.0), shift=0x3F000000 (0.5). Stream in_sof=1 x=5.0, then x=0xC0200000 (-2.5), mode=00 → 0x3FC00000 (1.5) ch0, then 0xC0900000 (-4.5) ch1, back-to-back.
- Same stream, mode=01 → 0x3FC00000, then 0x00000000.
- NUM_CH=4; send 6 beats without in_sof → out_ch 0,1,2,3,0,1. A 7th beat with in_sof=1 → out_ch=0.
- out_ready held low 5 cycles mid-stream of 10 beats → in_ready low once output is full, out_data stable while blocked, all 10 results in order with no loss or duplication.
- x=0x7F800000 (Inf), scale=0 → 0x7FC00000.
- mode=10 with x=0x80000000 → 0x80000000.
- Assert rst while 3 beats are in flight → no out_valid afterwards until new input arrives.

Source files
------------

// File: rtl/fp32_batchnorm_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp32_batchnorm_mc_pkg
// Brief  : Shared encodings and fp32 constants for the batch-norm datapath.
// Rev    : 1.0
// ============================================================================
package fp32_batchnorm_mc_pkg;

    typedef enum logic [1:0] {
        MODE_AFFINE = 2'b00,
        MODE_RELU   = 2'b01,
        MODE_BYPASS = 2'b10,
        MODE_RSVD   = 2'b11
    } bn_mode_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } fp_rm_e;

    localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    function automatic logic fp32_is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_scale_shift.sv
`default_nettype none
// ============================================================================
// Module : fp32_scale_shift
// Brief  : Pipelined y = round(round(x*scale)+shift), FTZ/DAZ, stall via en.
// Rev    : 1.0
// ============================================================================
module fp32_scale_shift
    import fp32_batchnorm_mc_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int ADD_LAT = 3
) (
    input  logic        clk,
    input  logic        en,
    input  logic [31:0] x,
    input  logic [31:0] scale,
    input  logic [31:0] shift,
    input  logic [1:0]  rm,
    output logic [31:0] y
);

    function automatic logic [31:0] round_pack(input logic s, input logic signed [11:0] e,
                                               input logic [22:0] frac, input logic g,
                                               input logic st, input logic [1:0] r);
        logic               inc;
        logic [23:0]        mr;
        logic signed [11:0] er;
        logic               ovf_inf;
        case (r)
            RM_RNE:  inc = g & (st | frac[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~s & (g | st);
            default: inc = s & (g | st);
        endcase
        mr = {1'b0, frac} + 24'(inc);
        er = e;
        // carry out of the fraction leaves it zero and bumps the exponent
        if (mr[23]) er = e + 12'sd1;
        if (er <= 12'sd0) return {s, 31'd0};
        if (er >= 12'sd255) begin
            ovf_inf = (r == RM_RNE) || (r == RM_RUP && !s) || (r == RM_RDN && s);
            return ovf_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7F_FFFF};
        end
        return {s, er[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] r);
        logic               s, za, zb, ia, ib;
        logic [47:0]        p;
        logic signed [11:0] e;
        s  = a[31] ^ b[31];
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF);
        ib = (b[30:23] == 8'hFF);
        if (fp32_is_nan(a) || fp32_is_nan(b)) return FP32_QNAN;
        if ((ia && zb) || (ib && za)) return FP32_QNAN;
        if (ia || ib) return {s, 8'hFF, 23'd0};
        if (za || zb) return {s, 31'd0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
        if (p[47]) return round_pack(s, e + 12'sd1, p[46:24], p[23], |p[22:0], r);
        return round_pack(s, e, p[45:23], p[22], |p[21:0], r);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] r);
        logic               za, zb, ia, ib, st;
        logic [31:0]        big, sml;
        logic [7:0]         d;
        logic [49:0]        mb, ms, msh;
        logic [50:0]        sum, n;
        logic signed [11:0] e;
        int                 lead;
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF);
        ib = (b[30:23] == 8'hFF);
        if (fp32_is_nan(a) || fp32_is_nan(b)) return FP32_QNAN;
        if (ia && ib && (a[31] != b[31])) return FP32_QNAN;
        if (ia) return {a[31], 8'hFF, 23'd0};
        if (ib) return {b[31], 8'hFF, 23'd0};
        if (za && zb) return {(r == RM_RDN) ? (a[31] | b[31]) : (a[31] & b[31]), 31'd0};
        if (za) return b;
        if (zb) return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        mb = {1'b1, big[22:0], 26'd0};
        ms = {1'b1, sml[22:0], 26'd0};
        // shifted-out bits collapse into a sticky bit well below the round position
        if (d >= 8'd50) begin
            msh = 50'd1;
        end else begin
            msh    = ms >> d;
            st     = |(ms & ~({50{1'b1}} << d));
            msh[0] = msh[0] | st;
        end
        sum = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, msh}) : ({1'b0, mb} - {1'b0, msh});
        if (sum == 51'd0) return {(r == RM_RDN), 31'd0};
        lead = 0;
        for (int i = 0; i < 51; i++) begin
            if (sum[i]) lead = i;
        end
        n = sum << (50 - lead);
        e = $signed({4'd0, big[30:23]}) + $signed(12'(lead)) - 12'sd49;
        return round_pack(big[31], e, n[49:27], n[26], |n[25:0], r);
    endfunction

    logic [31:0] prod_q  [MUL_LAT];
    logic [31:0] prod_d  [MUL_LAT];
    logic [31:0] mshift_q[MUL_LAT];
    logic [31:0] mshift_d[MUL_LAT];
    logic [1:0]  mrm_q   [MUL_LAT];
    logic [1:0]  mrm_d   [MUL_LAT];
    logic [31:0] sum_q   [ADD_LAT];
    logic [31:0] sum_d   [ADD_LAT];

    always_comb begin
        prod_d   = prod_q;
        mshift_d = mshift_q;
        mrm_d    = mrm_q;
        sum_d    = sum_q;
        if (en) begin
            prod_d[0]   = fp_mul(x, scale, rm);
            mshift_d[0] = shift;
            mrm_d[0]    = rm;
            for (int i = 1; i < MUL_LAT; i++) begin
                prod_d[i]   = prod_q[i-1];
                mshift_d[i] = mshift_q[i-1];
                mrm_d[i]    = mrm_q[i-1];
            end
            sum_d[0] = fp_add(prod_q[MUL_LAT-1], mshift_q[MUL_LAT-1], mrm_q[MUL_LAT-1]);
            for (int i = 1; i < ADD_LAT; i++) begin
                sum_d[i] = sum_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        prod_q   <= prod_d;
        mshift_q <= mshift_d;
        mrm_q    <= mrm_d;
        sum_q    <= sum_d;
    end

    assign y = sum_q[ADD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/fp32_batchnorm_mc.sv
`default_nettype none
// ============================================================================
// Module : fp32_batchnorm_mc
// Brief  : Streaming multi-channel fp32 batch-norm with ReLU/bypass modes.
// Rev    : 1.0
// ============================================================================
module fp32_batchnorm_mc
    import fp32_batchnorm_mc_pkg::*;
#(
    parameter int  NUM_CH   = 16,
    parameter int  MUL_LAT  = 3,
    parameter int  ADD_LAT  = 3,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PIPE_LAT = MUL_LAT + ADD_LAT + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_sof,
    input  logic [1:0]      mode,
    input  logic [1:0]      rm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [CH_W-1:0] out_ch,
    input  logic            cfg_we,
    input  logic            cfg_sel,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [31:0]     cfg_data
);

    localparam int              CORE_LAT = PIPE_LAT - 2;
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [31:0]     scale_q [NUM_CH];
    logic [31:0]     scale_d [NUM_CH];
    logic [31:0]     shift_q [NUM_CH];
    logic [31:0]     shift_d [NUM_CH];

    logic            advance, accept;
    logic [CH_W-1:0] ch_in, cnt_q, cnt_d;
    logic            v0_q, v0_d;
    logic [31:0]     x0_q, x0_d, sc0_q, sc0_d, sh0_q, sh0_d;
    logic [CH_W-1:0] ch0_q, ch0_d;
    logic [1:0]      mode0_q, mode0_d, rm0_q, rm0_d;
    logic            sv_q   [CORE_LAT];
    logic            sv_d   [CORE_LAT];
    logic [31:0]     sx_q   [CORE_LAT];
    logic [31:0]     sx_d   [CORE_LAT];
    logic [CH_W-1:0] sch_q  [CORE_LAT];
    logic [CH_W-1:0] sch_d  [CORE_LAT];
    logic [1:0]      smode_q[CORE_LAT];
    logic [1:0]      smode_d[CORE_LAT];
    logic [31:0]     core_y, mux_y;
    logic            mv_q, mv_d;
    logic [31:0]     mdata_q, mdata_d;
    logic [CH_W-1:0] mch_q, mch_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;

    // config writes ignore stall; lookups this cycle still see the old value
    always_comb begin
        scale_d = scale_q;
        shift_d = shift_q;
        if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
            if (cfg_sel) shift_d[cfg_ch] = cfg_data;
            else         scale_d[cfg_ch] = cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i] <= FP32_ONE;
                shift_q[i] <= FP32_ZERO;
            end
        end else begin
            scale_q <= scale_d;
            shift_q <= shift_d;
        end
    end

    fp32_scale_shift #(
        .MUL_LAT (MUL_LAT),
        .ADD_LAT (ADD_LAT)
    ) u_core (
        .clk   (clk),
        .en    (advance),
        .x     (x0_q),
        .scale (sc0_q),
        .shift (sh0_q),
        .rm    (rm0_q),
        .y     (core_y)
    );

    always_comb begin
        mux_y = core_y;
        if (smode_q[CORE_LAT-1] == MODE_BYPASS) begin
            mux_y = sx_q[CORE_LAT-1];
        end else if ((smode_q[CORE_LAT-1] == MODE_RELU) && core_y[31] && !fp32_is_nan(core_y)) begin
            mux_y = FP32_ZERO;
        end
    end

    always_comb begin
        advance     = !out_valid_q || out_ready;
        accept      = in_valid && advance;
        ch_in       = in_sof ? '0 : cnt_q;
        cnt_d       = cnt_q;
        v0_d        = v0_q;
        x0_d        = x0_q;
        sc0_d       = sc0_q;
        sh0_d       = sh0_q;
        ch0_d       = ch0_q;
        mode0_d     = mode0_q;
        rm0_d       = rm0_q;
        sv_d        = sv_q;
        sx_d        = sx_q;
        sch_d       = sch_q;
        smode_d     = smode_q;
        mv_d        = mv_q;
        mdata_d     = mdata_q;
        mch_d       = mch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (accept) cnt_d = (ch_in == LAST_CH) ? '0 : ch_in + 1'b1;
        if (advance) begin
            v0_d       = accept;
            x0_d       = in_data;
            sc0_d      = scale_q[ch_in];
            sh0_d      = shift_q[ch_in];
            ch0_d      = ch_in;
            mode0_d    = mode;
            rm0_d      = rm;
            sv_d[0]    = v0_q;
            sx_d[0]    = x0_q;
            sch_d[0]   = ch0_q;
            smode_d[0] = mode0_q;
            for (int i = 1; i < CORE_LAT; i++) begin
                sv_d[i]    = sv_q[i-1];
                sx_d[i]    = sx_q[i-1];
                sch_d[i]   = sch_q[i-1];
                smode_d[i] = smode_q[i-1];
            end
            mv_d        = sv_q[CORE_LAT-1];
            mdata_d     = mux_y;
            mch_d       = sch_q[CORE_LAT-1];
            out_valid_d = mv_q;
            out_data_d  = mdata_q;
            out_ch_d    = mch_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            v0_q        <= 1'b0;
            for (int i = 0; i < CORE_LAT; i++) sv_q[i] <= 1'b0;
            mv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= FP32_ZERO;
            out_ch_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            v0_q        <= v0_d;
            sv_q        <= sv_d;
            mv_q        <= mv_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    always_ff @(posedge clk) begin
        x0_q    <= x0_d;
        sc0_q   <= sc0_d;
        sh0_q   <= sh0_d;
        ch0_q   <= ch0_d;
        mode0_q <= mode0_d;
        rm0_q   <= rm0_d;
        sx_q    <= sx_d;
        sch_q   <= sch_d;
        smode_q <= smode_d;
        mdata_q <= mdata_d;
        mch_q   <= mch_d;
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_batchnorm_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_fp32_batchnorm_mc
// Brief  : Directed self-checking bench for fp32_batchnorm_mc (NUM_CH = 4).
// Rev    : 1.0
// ============================================================================
module tb_fp32_batchnorm_mc;

    localparam int LAT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [1:0]  rm = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_data = '0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int accept_cyc = 0;

    logic [31:0] cap_data[$];
    logic [1:0]  cap_ch[$];
    int          cap_cyc[$];

    fp32_batchnorm_mc #(.NUM_CH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .mode(mode), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
        .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_ch.push_back(out_ch);
            cap_cyc.push_back(cyc);
        end
    end

    task automatic clear_caps();
        cap_data.delete();
        cap_ch.delete();
        cap_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_write(input logic sel, input logic [1:0] ch, input logic [31:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic sof, input logic [1:0] md, input logic [1:0] r);
        int g;
        g = 0;
        in_valid = 1'b1; in_data = x; in_sof = sof; mode = md; rm = r;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            n_total++;
            $display("FAIL send_timeout in_ready stuck low for %0d cycles", g);
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic wait_caps(input int n);
        int g;
        g = 0;
        while (cap_data.size() < n && g < 300) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (cap_data.size() < n) begin
            n_total++;
            $display("FAIL wait_caps got %0d outputs, need %0d", cap_data.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL rst_data got %h want 00000000", out_data); else n_pass++;
        n_total++; if (out_ch !== 2'd0) $display("FAIL rst_ch got %0d want 0", out_ch); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        clear_caps();
        send(32'h40A00000, 1'b1, 2'b00, 2'b00);
        wait_caps(1);
        n_total++; if (cap_data[0] !== 32'h40A00000) $display("FAIL ident_data got %h want 40a00000", cap_data[0]); else n_pass++;
        n_total++; if (cap_ch[0] !== 2'd0) $display("FAIL ident_ch got %0d want 0", cap_ch[0]); else n_pass++;
        n_total++; if (cap_cyc[0] - accept_cyc != LAT) $display("FAIL ident_latency got %0d want %0d", cap_cyc[0] - accept_cyc, LAT); else n_pass++;
    endtask

    task automatic test_affine();
        cfg_write(1'b0, 2'd0, 32'h3F000000);
        cfg_write(1'b1, 2'd0, 32'hBF800000);
        cfg_write(1'b0, 2'd1, 32'h40000000);
        cfg_write(1'b1, 2'd1, 32'h3F000000);
        clear_caps();
        send(32'h40A00000, 1'b1, 2'b00, 2'b00);
        send(32'hC0200000, 1'b0, 2'b00, 2'b00);
        wait_caps(2);
        n_total++; if (cap_data[0] !== 32'h3FC00000) $display("FAIL affine0_data got %h want 3fc00000", cap_data[0]); else n_pass++;
        n_total++; if (cap_ch[0] !== 2'd0) $display("FAIL affine0_ch got %0d want 0", cap_ch[0]); else n_pass++;
        n_total++; if (cap_data[1] !== 32'hC0900000) $display("FAIL affine1_data got %h want c0900000", cap_data[1]); else n_pass++;
        n_total++; if (cap_ch[1] !== 2'd1) $display("FAIL affine1_ch got %0d want 1", cap_ch[1]); else n_pass++;
        n_total++; if (cap_cyc[1] != cap_cyc[0] + 1) $display("FAIL affine_b2b gap got %0d want 1", cap_cyc[1] - cap_cyc[0]); else n_pass++;
    endtask

    task automatic test_relu();
        clear_caps();
        send(32'h40A00000, 1'b1, 2'b01, 2'b00);
        send(32'hC0200000, 1'b0, 2'b01, 2'b00);
        wait_caps(2);
        n_total++; if (cap_data[0] !== 32'h3FC00000) $display("FAIL relu0_data got %h want 3fc00000", cap_data[0]); else n_pass++;
        n_total++; if (cap_data[1] !== 32'h00000000) $display("FAIL relu1_data got %h want 00000000", cap_data[1]); else n_pass++;
    endtask

    task automatic test_channel_wrap();
        logic [1:0]  exp_ch[7];
        logic [31:0] xv;
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
        do_reset();
        clear_caps();
        for (int i = 0; i < 7; i++) begin
            xv = 32'h40000000 + (i << 20);
            send(xv, (i == 6), 2'b00, 2'b00);
        end
        wait_caps(7);
        for (int i = 0; i < 7; i++) begin
            xv = 32'h40000000 + (i << 20);
            n_total++; if (cap_ch[i] !== exp_ch[i]) $display("FAIL wrap_ch[%0d] got %0d want %0d", i, cap_ch[i], exp_ch[i]); else n_pass++;
            n_total++; if (cap_data[i] !== xv) $display("FAIL wrap_data[%0d] got %h want %h", i, cap_data[i], xv); else n_pass++;
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] snap;
        logic [31:0] xv;
        clear_caps();
        fork
            begin
                for (int i = 0; i < 10; i++) send(32'h41000000 + (i << 20), 1'b0, 2'b00, 2'b00);
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                snap = out_data;
                for (int k = 0; k < 5; k++) begin
                    n_total++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", k, out_valid); else n_pass++;
                    n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", k, in_ready); else n_pass++;
                    n_total++; if (out_data !== snap) $display("FAIL stall_hold[%0d] got %h want %h", k, out_data, snap); else n_pass++;
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_caps(10);
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (cap_data.size() != 10) $display("FAIL stall_count got %0d want 10", cap_data.size()); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            xv = 32'h41000000 + (i << 20);
            n_total++; if (cap_data[i] !== xv) $display("FAIL stall_order[%0d] got %h want %h", i, cap_data[i], xv); else n_pass++;
        end
    endtask

    task automatic test_specials();
        logic [31:0] xs[8];
        logic [1:0]  ms[8];
        logic [1:0]  rs[8];
        logic [31:0] ex[8];
        cfg_write(1'b0, 2'd0, 32'h00000000);
        clear_caps();
        send(32'h7F800000, 1'b1, 2'b00, 2'b00);
        wait_caps(1);
        n_total++; if (cap_data[0] !== 32'h7FC00000) $display("FAIL inf_times_zero got %h want 7fc00000", cap_data[0]); else n_pass++;
        cfg_write(1'b0, 2'd0, 32'h40800000);
        xs = '{32'h7F000000, 32'h7F000000, 32'h80000000, 32'h80000000,
               32'h7F800001, 32'h00000005, 32'hC0000000, 32'h3F800000};
        ms = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b11};
        rs = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        ex = '{32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h00000000,
               32'h7FC00000, 32'h00000000, 32'h00000000, 32'h40800000};
        clear_caps();
        for (int i = 0; i < 8; i++) send(xs[i], 1'b1, ms[i], rs[i]);
        wait_caps(8);
        for (int i = 0; i < 8; i++) begin
            n_total++; if (cap_data[i] !== ex[i]) $display("FAIL special[%0d] x=%h got %h want %h", i, xs[i], cap_data[i], ex[i]); else n_pass++;
        end
    endtask

    task automatic test_cfg_collision();
        cfg_write(1'b0, 2'd0, 32'h3F800000);
        clear_caps();
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL coll_in_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h40400000; in_sof = 1'b1; mode = 2'b00; rm = 2'b00;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 32'h40000000;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0; cfg_we = 1'b0;
        send(32'h40400000, 1'b1, 2'b00, 2'b00);
        wait_caps(2);
        n_total++; if (cap_data[0] !== 32'h40400000) $display("FAIL coll_old got %h want 40400000", cap_data[0]); else n_pass++;
        n_total++; if (cap_data[1] !== 32'h40C00000) $display("FAIL coll_new got %h want 40c00000", cap_data[1]); else n_pass++;
    endtask

    task automatic test_reset_inflight();
        int seen;
        seen = 0;
        clear_caps();
        send(32'h3F800000, 1'b1, 2'b00, 2'b00);
        send(32'h40000000, 1'b0, 2'b00, 2'b00);
        send(32'h40400000, 1'b0, 2'b00, 2'b00);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL inflight_flush out_valid seen %0d cycles want 0", seen); else n_pass++;
        @(posedge clk); #1;
        clear_caps();
        send(32'h41200000, 1'b0, 2'b00, 2'b00);
        wait_caps(1);
        n_total++; if (cap_data[0] !== 32'h41200000) $display("FAIL post_rst_data got %h want 41200000", cap_data[0]); else n_pass++;
        n_total++; if (cap_ch[0] !== 2'd0) $display("FAIL post_rst_ch got %0d want 0", cap_ch[0]); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_affine();
        test_relu();
        test_channel_wrap();
        test_back_to_back_stall();
        test_specials();
        test_cfg_collision();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
